// File: rtl/force_fetch_sequencer.sv
// force_fetch_sequencer: after a force pass, waits for the force cache write
// buffers to drain, sweeps particle IDs 0..N-1 through the shared cache read
// port, and streams {home lanes, neighbour force, particle ID} to motion update.
// Reads are credit-limited so the show-ahead output FIFO can never overflow.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_start, i_num_particles  start pulse and particle count N (latched in IDLE)
//   i_home_buf_empty          home force cache write buffers empty
//   i_nb_buf_empty            neighbour force cache write buffer empty
//   i_home_frc, i_nb_frc      cache read data, RD_LATENCY cycles after o_MU_rd_en
//   o_MU_rd_addr, o_MU_rd_en  cache read port
//   o_home_frc, o_nb_frc,
//   o_parid, o_frc_valid      FIFO head toward MU
//   i_frc_ready               MU accepts the head
//   o_busy, o_done            pass in progress / one-cycle end-of-pass pulse
//   o_stall_cycles            only with FORCE_FETCH_STATS_EN: stalled valid cycles
//
// Optional feature macro: FORCE_FETCH_STATS_EN
module force_fetch_sequencer #(
   parameter int unsigned FLOAT_STRUCT_WIDTH = 96,
   parameter int unsigned NUM_PES_PER_CELL   = 2,
   parameter int unsigned PARTICLE_ID_WIDTH  = 7,
   parameter int unsigned RD_LATENCY         = 2,
   parameter int unsigned FIFO_DEPTH         = 4
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          i_start,
   input  logic [PARTICLE_ID_WIDTH:0]                    i_num_particles,
   input  logic                                          i_home_buf_empty,
   input  logic                                          i_nb_buf_empty,
   input  logic [FLOAT_STRUCT_WIDTH*NUM_PES_PER_CELL-1:0] i_home_frc,
   input  logic [FLOAT_STRUCT_WIDTH-1:0]                 i_nb_frc,
   output logic [PARTICLE_ID_WIDTH-1:0]                  o_MU_rd_addr,
   output logic                                          o_MU_rd_en,
   output logic [FLOAT_STRUCT_WIDTH*NUM_PES_PER_CELL-1:0] o_home_frc,
   output logic [FLOAT_STRUCT_WIDTH-1:0]                 o_nb_frc,
   output logic [PARTICLE_ID_WIDTH-1:0]                  o_parid,
   output logic                                          o_frc_valid,
   input  logic                                          i_frc_ready,
`ifdef FORCE_FETCH_STATS_EN
   output logic [31:0]                                   o_stall_cycles,
`endif
   output logic                                          o_busy,
   output logic                                          o_done
);

   localparam int unsigned HW = FLOAT_STRUCT_WIDTH * NUM_PES_PER_CELL;
   localparam int unsigned FW = FLOAT_STRUCT_WIDTH;
   localparam int unsigned PW = PARTICLE_ID_WIDTH;
   localparam int unsigned NW = PARTICLE_ID_WIDTH + 1;
   localparam int unsigned EW = HW + FW + PW;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SW = CW + 1;

   typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_READ, S_FLUSH, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [NW-1:0]   r_num;
   logic [NW-1:0]   r_addr;
   logic [PW-1:0]   r_last_addr;
   logic            r_empty_prev;
   logic            w_rd_en;
   logic            w_both_empty;
   logic            w_credit;
   logic            w_last_addr;

   logic [RD_LATENCY-1:0] r_pipe_vld;
   logic [PW-1:0]   r_pipe_id [RD_LATENCY];
   logic [CW-1:0]   r_inflight;

   logic [EW-1:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_fifo_count;
   logic            w_push;
   logic            w_pop;
   logic            w_valid;
   logic [EW-1:0]   w_head;

   assign w_both_empty = i_home_buf_empty && i_nb_buf_empty;
   // Credit: a slot is reserved in the FIFO for every read still in the pipe.
   assign w_credit     = (SW'(r_inflight) + SW'(r_fifo_count)) < SW'(FIFO_DEPTH);
   assign w_last_addr  = (r_addr + NW'(1)) == r_num;

   // Next-state and read-issue decode
   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_both_empty && r_empty_prev)
                     w_state_nxt = (r_num == '0) ? S_FLUSH : S_READ;
         S_READ: begin
            w_rd_en = w_credit;
            if (w_credit && w_last_addr) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: if ((r_inflight == '0) && (r_fifo_count == '0)) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register and sweep control
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_num        <= '0;
         r_addr       <= '0;
         r_last_addr  <= '0;
         r_empty_prev <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == S_IDLE) && i_start) begin
            r_num  <= i_num_particles;
            r_addr <= '0;
         end
         // Both buffers must read empty on two back-to-back DRAIN cycles.
         r_empty_prev <= (r_state == S_DRAIN) && w_both_empty;
         if (w_rd_en) begin
            r_addr      <= r_addr + NW'(1);
            r_last_addr <= r_addr[PW-1:0];
         end
      end
   end

   // Read pipe tracking {valid, parid} alongside the cache latency
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pipe_vld <= '0;
         r_pipe_id  <= '{default: '0};
         r_inflight <= '0;
      end else begin
         r_pipe_vld[0] <= w_rd_en;
         r_pipe_id[0]  <= r_addr[PW-1:0];
         for (int i = 1; i < int'(RD_LATENCY); i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_id[i]  <= r_pipe_id[i-1];
         end
         r_inflight <= r_inflight + CW'(w_rd_en) - CW'(w_push);
      end
   end

   assign w_push  = r_pipe_vld[RD_LATENCY-1];
   assign w_valid = (r_fifo_count != '0);
   assign w_pop   = w_valid && i_frc_ready;
   assign w_head  = r_mem[r_rd_ptr];

   // FIFO storage; contents need no reset because the head is gated by valid
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {i_home_frc, i_nb_frc, r_pipe_id[RD_LATENCY-1]};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_fifo_count <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_fifo_count <= r_fifo_count + CW'(w_push) - CW'(w_pop);
      end
   end

   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_push && !w_pop && (r_fifo_count == CW'(FIFO_DEPTH))));

`ifdef FORCE_FETCH_STATS_EN
   logic [31:0] r_stall_cycles;

   // Saturating count of cycles where MU holds off a valid head
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= '0;
      end else if ((r_state == S_IDLE) && i_start) begin
         r_stall_cycles <= '0;
      end else if (w_valid && !i_frc_ready && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign o_stall_cycles = r_stall_cycles;
`else
   // Stall statistics not built.
`endif

   assign o_MU_rd_en   = w_rd_en;
   assign o_MU_rd_addr = w_rd_en ? r_addr[PW-1:0] : r_last_addr;
   assign o_frc_valid  = w_valid;
   assign o_home_frc   = w_valid ? w_head[EW-1 -: HW]      : '0;
   assign o_nb_frc     = w_valid ? w_head[PW+FW-1 -: FW]   : '0;
   assign o_parid      = w_valid ? w_head[PW-1:0]          : '0;
   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = (r_state == S_DONE);

endmodule
